// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the
// divider.
//   master (execute stage): drives signed_div_i, opdata1_i, opdata2_i,
//                           start_i, annul_i; receives result_o, ready_o
//   slave  (div_unit)     : the mirror image
interface div_unit_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_unit_if.slave
//          signed_div_i, opdata1_i (dividend), opdata2_i (divisor) sampled
//          with start_i; annul_i aborts an iteration in progress;
//          result_o = {remainder, quotient}, ready_o = result valid.
// Latency: 33 edges after the sampling edge (1 for a zero divisor).
// Build option: define DIV_SIGNED_EN to honour signed_div_i; otherwise
// every division is unsigned and no sign logic is built.
module div_unit (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [64:0] dividend;   // {partial remainder[32:0], dividend/quotient[31:0]}
  logic [31:0] divisor;    // divisor magnitude
  logic [64:0] step;
  logic [31:0] mag1, mag2;
  logic [31:0] quo, rem;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  // Operand magnitudes; 0x80000000 maps to itself, which is correct
  // when read as unsigned.
  always_comb begin
    mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
    mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;
  end

  // Quotient sign follows the sign XOR, remainder follows the dividend.
  always_comb begin
    quo = neg_q ? (32'd0 - dividend[31:0])  : dividend[31:0];
    rem = neg_r ? (32'd0 - dividend[63:32]) : dividend[63:32];
  end
`else
  always_comb begin
    mag1 = bus.opdata1_i;
    mag2 = bus.opdata2_i;
    quo  = dividend[31:0];
    rem  = dividend[63:32];
  end
`endif

  // One restoring step: shift, trial-subtract, set quotient bit.
  always_comb begin
    step = {dividend[63:0], 1'b0};
    if (step[64:32] >= {1'b0, divisor}) begin
      step[64:32] = step[64:32] - {1'b0, divisor};
      step[0]     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DIV_FREE;
      cnt          <= 6'd0;
      dividend     <= 65'd0;
      divisor      <= 32'd0;
      bus.result_o <= 64'd0;
      bus.ready_o  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
`endif
    end else begin
      case (state)
        DIV_FREE: begin
          bus.result_o <= 64'd0;
          bus.ready_o  <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == 32'd0) begin
              state <= DIV_BY_ZERO;
            end else begin
              state    <= DIV_ON;
              cnt      <= 6'd0;
              dividend <= {33'd0, mag1};
              divisor  <= mag2;
`ifdef DIV_SIGNED_EN
              neg_q    <= bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
              neg_r    <= bus.signed_div_i && bus.opdata1_i[31];
`endif
            end
          end
        end
        DIV_BY_ZERO: begin
          state        <= DIV_END;
          bus.result_o <= 64'd0;
          bus.ready_o  <= 1'b1;
        end
        DIV_ON: begin
          if (bus.annul_i) begin
            state <= DIV_FREE;
          end else if (cnt != 6'd32) begin
            dividend <= step;
            cnt      <= cnt + 6'd1;
          end else begin
            state        <= DIV_END;
            bus.result_o <= {rem, quo};
            bus.ready_o  <= 1'b1;
            cnt          <= 6'd0;
          end
        end
        DIV_END: begin
          if (!bus.start_i) begin
            state        <= DIV_FREE;
            bus.result_o <= 64'd0;
            bus.ready_o  <= 1'b0;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule
